// File: rtl/reg_file_mp_if.sv
// Bus bundle for reg_file_mp: two write lanes, NUM_RD packed read ports,
// clear request and the status outputs. The master drives the request side;
// the slave (the register file) drives read data and status.
interface reg_file_mp_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
);
  localparam int AW = $clog2(DEPTH);

  logic                     we0;
  logic [AW-1:0]            waddr0;
  logic [DATA_W-1:0]        wdata0;
  logic                     we1;
  logic [AW-1:0]            waddr1;
  logic [DATA_W-1:0]        wdata1;
  logic [NUM_RD*AW-1:0]     raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rvld;
  logic                     clr_req;
  logic                     clr_busy;
  logic                     wr_drop;

  modport master (
    output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    input  rdata, rvld, clr_busy, wr_drop
  );

  modport slave (
    input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, clr_req,
    output rdata, rvld, clr_busy, wr_drop
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: NUM_RD registered read ports with write-first
// forwarding, two write lanes (lane 1 wins on address collision), a valid bit
// per entry and a background clear sweep that zeroes one entry per cycle.
// Writes arriving while the sweep runs are discarded and flagged on wr_drop.
// Optional macro ZERO_REG_EN hardwires entry 0 to zero (reads 0 with valid=1,
// writes to it are ignored without a drop flag, never forwarded).
module reg_file_mp #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 2
) (
  input logic           clk,
  input logic           rst,
  reg_file_mp_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_t;

  state_t                   r_state;
  state_t                   w_stateNext;
  logic [AW-1:0]            r_idx;
  logic [AW-1:0]            w_idxNext;
  logic                     w_busy;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  logic [DEPTH-1:0]         r_valid;
  logic [NUM_RD*DATA_W-1:0] r_rdata;
  logic [NUM_RD-1:0]        r_rvld;
  logic                     r_wrDrop;

  logic                     w_live0;
  logic                     w_live1;
  logic                     w_acc0;
  logic                     w_acc1;

  // A write is "live" if it targets a writable entry; with the zero register
  // enabled, address 0 writes vanish entirely and never count as a drop.
`ifdef ZERO_REG_EN
  assign w_live0 = bus.we0 && (bus.waddr0 != '0);
  assign w_live1 = bus.we1 && (bus.waddr1 != '0);
`else
  assign w_live0 = bus.we0;
  assign w_live1 = bus.we1;
`endif
  assign w_acc0 = w_live0 && !w_busy;
  assign w_acc1 = w_live1 && !w_busy;

  // Clear FSM state and sweep index register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_idx   <= w_idxNext;
    end
  end

  // Clear FSM next state; the index only advances while sweeping and returns
  // to 0 on the exit from the last entry, so it never aliases past DEPTH-1.
  always_comb begin
    w_stateNext = r_state;
    w_idxNext   = r_idx;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.clr_req) begin
          w_stateNext = SWEEP;
          w_idxNext   = '0;
        end
      end
      SWEEP: begin
        w_busy = 1'b1;
        if (r_idx == AW'(DEPTH - 1)) begin
          w_stateNext = IDLE;
          w_idxNext   = '0;
        end else begin
          w_idxNext = r_idx + AW'(1);
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_idxNext   = '0;
      end
    endcase
  end

  // Array update: sweep clears one entry, accepted writes store data with
  // lane 1 placed last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_valid <= '0;
    end else begin
      if (w_busy) begin
        r_mem[r_idx]   <= '0;
        r_valid[r_idx] <= 1'b0;
      end
      if (w_acc0) begin
        r_mem[bus.waddr0]   <= bus.wdata0;
        r_valid[bus.waddr0] <= 1'b1;
      end
      if (w_acc1) begin
        r_mem[bus.waddr1]   <= bus.wdata1;
        r_valid[bus.waddr1] <= 1'b1;
      end
    end
  end

  function automatic logic [DATA_W-1:0] readData(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (a == '0) return '0;
`endif
    if (w_acc1 && (bus.waddr1 == a)) return bus.wdata1;
    if (w_acc0 && (bus.waddr0 == a)) return bus.wdata0;
    return r_mem[a];
  endfunction

  function automatic logic readValid(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    if (a == '0) return 1'b1;
`endif
    if (w_acc1 && (bus.waddr1 == a)) return 1'b1;
    if (w_acc0 && (bus.waddr0 == a)) return 1'b1;
    return r_valid[a];
  endfunction

  // Registered read ports with write-first forwarding, plus the drop flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata  <= '0;
      r_rvld   <= '0;
      r_wrDrop <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_RD; k++) begin
        r_rdata[k*DATA_W +: DATA_W] <= readData(bus.raddr[k*AW +: AW]);
        r_rvld[k]                   <= readValid(bus.raddr[k*AW +: AW]);
      end
      r_wrDrop <= w_busy && (w_live0 || w_live1);
    end
  end

  assign bus.rdata    = r_rdata;
  assign bus.rvld     = r_rvld;
  assign bus.wr_drop  = r_wrDrop;
  assign bus.clr_busy = w_busy;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed testbench for reg_file_mp (DATA_W=32, DEPTH=32, NUM_RD=2).
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_reg_file_mp;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   busyCount;

`ifdef ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  reg_file_mp_if #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) bus ();

  reg_file_mp #(.DATA_W(32), .DEPTH(32), .NUM_RD(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic w0, input logic [4:0] a0, input logic [31:0] d0,
                               input logic w1, input logic [4:0] a1, input logic [31:0] d1,
                               input logic [4:0] r0, input logic [4:0] r1);
    bus.we0    = w0;
    bus.waddr0 = a0;
    bus.wdata0 = d0;
    bus.we1    = w1;
    bus.waddr1 = a1;
    bus.wdata1 = d1;
    bus.raddr  = {r1, r0};
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Cleared contents: data 0, valid 0 except a hardwired zero register.
  task automatic readAllCleared(input string tag);
    for (int a = 0; a < 32; a++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      tick();
      checkOutput($sformatf("%s_rd0_a%0d", tag, a), bus.rdata[31:0], 32'h0);
      checkOutput($sformatf("%s_vld0_a%0d", tag, a), {31'h0, bus.rvld[0]}, {31'h0, ZeroReg && (a == 0)});
      checkOutput($sformatf("%s_rd1_a%0d", tag, 31 - a), bus.rdata[63:32], 32'h0);
      checkOutput($sformatf("%s_vld1_a%0d", tag, 31 - a), {31'h0, bus.rvld[1]}, {31'h0, ZeroReg && (a == 31)});
    end
  endtask

  initial begin
    total       = 0;
    bad         = 0;
    rst         = 1'b1;
    bus.clr_req = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    tick();
    rst = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_busy", {31'h0, bus.clr_busy}, 32'h0);
    checkOutput("rst_drop", {31'h0, bus.wr_drop}, 32'h0);
    checkOutput("rst_rdata0", bus.rdata[31:0], 32'h0);
    checkOutput("rst_rvld", {30'h0, bus.rvld}, 32'h0);
    readAllCleared("t1");

    $display("[TB] simple write then read");
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    tick();
    checkOutput("t2_rd0", bus.rdata[31:0], 32'hDEADBEEF);
    checkOutput("t2_vld0", {31'h0, bus.rvld[0]}, 32'h1);

    $display("[TB] dual-lane collision with forwarding");
    applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 5'd9, 5'd7);
    tick();
    checkOutput("t3_fwd1", bus.rdata[63:32], 32'h22222222);
    checkOutput("t3_fwdvld1", {31'h0, bus.rvld[1]}, 32'h1);
    checkOutput("t3_unwritten9", {31'h0, bus.rvld[0]}, 32'h0);
    applyStimulus(1'b1, 5'd9, 32'h0A0A0A0A, 1'b1, 5'd11, 32'hB0B0B0B0, 5'd9, 5'd7);
    tick();
    checkOutput("t3_fwd_lane0", bus.rdata[31:0], 32'h0A0A0A0A);
    checkOutput("t3_later7", bus.rdata[63:32], 32'h22222222);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd5);
    tick();
    checkOutput("t3_rd11", bus.rdata[31:0], 32'hB0B0B0B0);
    checkOutput("t3_rd5", bus.rdata[63:32], 32'hDEADBEEF);

    $display("[TB] fill and background clear");
    for (int a = 0; a < 32; a++) begin
      if (a % 2 == 0) applyStimulus(1'b1, 5'(a), 32'h1000 + 32'(a), 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      else            applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 32'h1000 + 32'(a), 5'd0, 5'd0);
      tick();
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd31);
    tick();
    checkOutput("t4_fill12", bus.rdata[31:0], 32'h100C);
    checkOutput("t4_fill31", bus.rdata[63:32], 32'h101F);
    checkOutput("t4_idle_busy", {31'h0, bus.clr_busy}, 32'h0);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      checkOutput($sformatf("t4_busy_c%0d", c), {31'h0, bus.clr_busy}, 32'h1);
      if (c == 5) bus.clr_req = 1'b1;
      if (c == 10) applyStimulus(1'b1, 5'd3, 32'h55555555, 1'b0, 5'd0, 32'h0, 5'd3, 5'd20);
      tick();
      bus.clr_req = 1'b0;
      checkOutput($sformatf("t4_drop_c%0d", c), {31'h0, bus.wr_drop}, {31'h0, c == 10});
      if (c == 10) begin
        checkOutput("t4_swept3_rd", bus.rdata[31:0], 32'h0);
        checkOutput("t4_swept3_vld", {31'h0, bus.rvld[0]}, 32'h0);
        checkOutput("t4_unswept20_rd", bus.rdata[63:32], 32'h1014);
        checkOutput("t4_unswept20_vld", {31'h0, bus.rvld[1]}, 32'h1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      end
    end
    checkOutput("t4_busy_end", {31'h0, bus.clr_busy}, 32'h0);
    readAllCleared("t4");

    $display("[TB] reset during sweep");
    applyStimulus(1'b1, 5'd2, 32'h000000AB, 1'b1, 5'd30, 32'h000000CD, 5'd0, 5'd0);
    tick();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd30, 5'd2);
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    checkOutput("t5_pre_rd30", bus.rdata[31:0], 32'h000000CD);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("t5_busy_c4", {31'h0, bus.clr_busy}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("t5_busy_after_rst", {31'h0, bus.clr_busy}, 32'h0);
    checkOutput("t5_rdata_after_rst", bus.rdata[31:0], 32'h0);
    readAllCleared("t5");
    bus.clr_req = 1'b1;
    tick();
    bus.clr_req = 1'b0;
    busyCount = 0;
    while (bus.clr_busy === 1'b1 && busyCount < 100) begin
      busyCount++;
      tick();
    end
    checkOutput("t5_sweep_len", 32'(busyCount), 32'd32);

    $display("[TB] address 0 behaviour");
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    checkOutput("t6_fwd0_rd", bus.rdata[31:0], ZeroReg ? 32'h0 : 32'hFFFFFFFF);
    checkOutput("t6_fwd0_vld", {31'h0, bus.rvld[0]}, 32'h1);
    checkOutput("t6_drop", {31'h0, bus.wr_drop}, 32'h0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    tick();
    checkOutput("t6_rd0", bus.rdata[31:0], ZeroReg ? 32'h0 : 32'hFFFFFFFF);
    checkOutput("t6_vld0", {31'h0, bus.rvld[0]}, 32'h1);
    checkOutput("t6_rd0_port1", bus.rdata[63:32], ZeroReg ? 32'h0 : 32'hFFFFFFFF);
    checkOutput("t6_drop_after", {31'h0, bus.wr_drop}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
Parametrised multi-port register file that generalises the 32x32 two-read/one-write register file. It has NUM_RD read ports and two write ports with a fixed priority rule. Reads are registered with same-cycle write forwarding (write-first). Each entry carries a valid bit, and a background clear sequencer zeroes the array one entry per cycle. It sits in the core datapath between decode (read addresses) and writeback (two retire lanes).

Parameters:
DATA_W, 32, width of each entry
DEPTH, 32, number of entries (power of two, >=2); AW = $clog2(DEPTH) is a localparam
NUM_RD, 2, number of read ports (1..8)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
we0  in  1  write enable, lane 0
waddr0  in  AW  write address, lane 0
wdata0  in  DATA_W  write data, lane 0
we1  in  1  write enable, lane 1 (higher priority)
waddr1  in  AW  write address, lane 1
wdata1  in  DATA_W  write data, lane 1
raddr  in  NUM_RD*AW  read addresses, port k at bits [k*AW +: AW]
rdata  out  NUM_RD*DATA_W  read data, port k at bits [k*DATA_W +: DATA_W]
rvld  out  NUM_RD  valid bit of the addressed entry, per port
clr_req  in  1  single-cycle pulse that starts the background clear
clr_busy  out  1  high while the clear sweep runs
wr_drop  out  1  pulses one cycle after any write is discarded due to clear

Behaviour:
- Reset (rst=1 at an edge):
  - all entries become 0 and all valid bits become 0;
  - rdata, rvld, wr_drop and clr_busy become 0;
  - the FSM goes to IDLE and the sweep index goes to 0;
  - reset overrides everything, including an in-progress sweep.
- Writes:
  - Take effect at the edge where weN=1.
  - The addressed entry takes wdataN and its valid bit is set.
  - If both lanes write the same address, lane 1 data is stored.
- Reads:
  - Latency is 1 cycle: rdata[k] and rvld[k] at cycle t+1 reflect raddr[k] sampled at t.
  - Forwarding: if raddr[k] matches an accepted write in cycle t, rdata[k] at t+1 holds that write's data (lane 1 wins) and rvld[k]=1.
  - All ports are independent; any ports may alias the same address.
- Clear FSM:
  - IDLE: clr_busy=0. On clr_req=1, go to SWEEP with index=0.
  - SWEEP: clr_busy=1. Each cycle, entry[index] is set to 0 and valid[index] to 0, then index increments.
  - When index==DEPTH-1 is cleared, return to IDLE. The sweep takes exactly DEPTH cycles.
  - clr_req during SWEEP is ignored (no restart).
- Writes while clr_busy=1:
  - The write is discarded and the array is unchanged.
  - wr_drop=1 on the following cycle (one pulse per cycle with any discard).
  - The write in the same cycle clr_req is sampled in IDLE is accepted.
- Reads during SWEEP:
  - Return current contents; already-swept entries read 0 with rvld=0.
  - Forwarding does not apply to discarded writes.
- Index counter wraps only via the FSM exit; no aliasing past DEPTH-1.

Optional Feature:
ZERO_REG_EN
- Defined:
  - entry 0 is hardwired to zero;
  - writes to address 0 are silently ignored (no wr_drop);
  - reads of address 0 return 0 with rvld=1;
  - forwarding is never applied for address 0.
- Undefined: entry 0 is an ordinary entry.

Test Plan:
1. Reset, then read addresses 0..31 on all ports -> rdata=0x0 and rvld=0 for every read.
2. we0=1, waddr0=5, wdata0=0xDEADBEEF; next cycle raddr port0=5 -> one cycle later rdata0=0xDEADBEEF, rvld0=1.
3. Same cycle: we0 (addr 7, 0x11111111), we1 (addr 7, 0x22222222), raddr port1=7 -> rdata1=0x22222222 next cycle (forwarded); a later read of 7 also returns 0x22222222.
4. Fill all 32 entries, pulse clr_req -> clr_busy=1 for exactly 32 cycles. A we0 to addr 3 in sweep cycle 10 is discarded with wr_drop=1 next cycle. Afterwards all reads return 0 with rvld=0.
5. Assert rst in sweep cycle 4 -> clr_busy=0 the following cycle and all entries read 0. A fresh clr_req then takes the full 32 cycles.
6. With ZERO_REG_EN defined: we0 to addr 0 with data 0xFFFFFFFF, then read addr 0 -> rdata=0, rvld=1, wr_drop stays 0.
